avalon_timer_sched: RTL

Avalon-MM master that configures and services the 16-bit-register interval timer in the quadcopter interface. After reset it programs the timer period and enables its interrupt. It then acknowledges every timeout by clearing the timer status. Each acknowledged timeout becomes a one-cycle base tick, which drives NUM_CH programmable rate dividers. These dividers schedule the control-loop tasks (PWM update, IMU poll, telemetry), with per-channel pending/ack tracking and sticky overrun flags.

---
 rtl/avalon_timer_sched.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/avalon_timer_sched.sv
// Avalon-MM master that boots and services a 16-bit-register interval timer,
// turning each serviced timeout into a base tick that feeds NUM_CH rate dividers.
module avalon_timer_sched #(
    parameter logic [31:0] PERIOD_DEFAULT = 32'd49999,
    parameter int          NUM_CH         = 4,
    parameter int          DIV_W          = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic [2:0]              m_address,
    output logic                    m_chipselect,
    output logic                    m_write_n,
    output logic [15:0]             m_writedata,
    input  logic                    timer_irq,
    input  logic [31:0]             cfg_period,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [NUM_CH*DIV_W-1:0] ch_div,
    input  logic [NUM_CH-1:0]       ch_ack,
    input  logic                    overrun_clr,
    output logic                    base_tick,
    output logic [15:0]             tick_count,
    output logic [NUM_CH-1:0]       ch_tick,
    output logic [NUM_CH-1:0]       ch_pending,
    output logic [NUM_CH-1:0]       ch_overrun,
    output logic                    running
);

    typedef enum logic [2:0] {
        BOOT,
        WR_PL,
        WR_PH,
        WR_CTRL,
        IDLE,
        CLR,
        SETTLE
    } state_t;

    localparam logic [31:0]      PERIOD_MIN = 32'd7;
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] period;
    logic [31:0] period_nxt;
    logic        accept;
    logic        wr_nxt;
    logic [2:0]  addr_nxt;
    logic [15:0] data_nxt;

    logic [DIV_W-1:0] cnt [NUM_CH];

    always_comb begin
        state_nxt  = state;
        period_nxt = period;
        accept     = 1'b0;
        unique case (state)
            BOOT: begin
                period_nxt = PERIOD_DEFAULT;
                state_nxt  = WR_PL;
            end
            WR_PL:   state_nxt = WR_PH;
            WR_PH:   state_nxt = WR_CTRL;
            WR_CTRL: state_nxt = IDLE;
            IDLE: begin
                // A pending timeout always wins so no tick is lost to a reconfiguration
                if (timer_irq) begin
                    state_nxt = CLR;
                end else if (cfg_valid) begin
                    accept     = 1'b1;
                    period_nxt = (cfg_period < PERIOD_MIN) ? PERIOD_MIN : cfg_period;
                    state_nxt  = WR_PL;
                end
            end
            CLR:     state_nxt = SETTLE;
            SETTLE:  state_nxt = IDLE;
            default: state_nxt = BOOT;
        endcase
    end

    // Bus values are decoded from the state being entered and registered with it
    always_comb begin
        wr_nxt   = 1'b0;
        addr_nxt = 3'd0;
        data_nxt = 16'h0000;
        case (state_nxt)
            WR_PL: begin
                wr_nxt   = 1'b1;
                addr_nxt = 3'd2;
                data_nxt = period_nxt[15:0];
            end
            WR_PH: begin
                wr_nxt   = 1'b1;
                addr_nxt = 3'd3;
                data_nxt = period_nxt[31:16];
            end
            WR_CTRL: begin
                wr_nxt   = 1'b1;
                addr_nxt = 3'd1;
                data_nxt = 16'h0001;
            end
            CLR: begin
                wr_nxt   = 1'b1;
                addr_nxt = 3'd0;
                data_nxt = 16'h0000;
            end
            default: begin
                wr_nxt   = 1'b0;
                addr_nxt = 3'd0;
                data_nxt = 16'h0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= BOOT;
            period       <= PERIOD_DEFAULT;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= 3'd0;
            m_writedata  <= 16'h0000;
            cfg_ready    <= 1'b0;
            base_tick    <= 1'b0;
            tick_count   <= 16'h0000;
            running      <= 1'b0;
        end else begin
            state        <= state_nxt;
            period       <= period_nxt;
            m_chipselect <= wr_nxt;
            m_write_n    <= ~wr_nxt;
            m_address    <= addr_nxt;
            m_writedata  <= data_nxt;
            cfg_ready    <= accept;
            base_tick    <= (state_nxt == CLR);
            if (state_nxt == CLR) begin
                tick_count <= tick_count + 16'd1;
            end
            if (state == WR_CTRL) begin
                running <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
            ch_tick    <= '0;
            ch_pending <= '0;
            ch_overrun <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch_tick[i] <= 1'b0;
                if (base_tick) begin
                    // >= rather than == so a shrunk divisor cannot strand the counter
                    if (ch_div[i*DIV_W +: DIV_W] == '0) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] >= ch_div[i*DIV_W +: DIV_W] - DIV_ONE) begin
                        cnt[i]     <= '0;
                        ch_tick[i] <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] + DIV_ONE;
                    end
                end
            end
            ch_pending <= ch_tick | (ch_pending & ~ch_ack);
            ch_overrun <= (ch_tick & ch_pending & ~ch_ack)
                        | (ch_overrun & ~{NUM_CH{overrun_clr}});
        end
    end

endmodule
